// File: rtl/seg_time_display.sv
// seg_time_display: multiplexes a 3-digit BCD game timer onto a common-anode 7-segment display
// with leading-zero blanking, an overflow indication and game-over blinking.
module seg_time_display #(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] time_1s,
  input  logic [3:0] time_10s,
  input  logic [3:0] time_100s,
  input  logic       time_max_flag,
  input  logic       game_over,
  output logic [2:0] sel,
  output logic [7:0] seg
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [3:0]    d1_q, d1_d, d10_q, d10_d, d100_q, d100_d;
  logic          max_q, max_d;
  logic          load_q;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic          slot_tick, blink_wrap, snap, blank_h, blank_t, digit_blank, off;
  logic [3:0]    digit;
  logic [7:0]    seg_on;

  function automatic logic [7:0] dec(input logic [3:0] v);
    case (v)
      4'd0:    dec = 8'hC0;
      4'd1:    dec = 8'hF9;
      4'd2:    dec = 8'hA4;
      4'd3:    dec = 8'hB0;
      4'd4:    dec = 8'h99;
      4'd5:    dec = 8'h92;
      4'd6:    dec = 8'h82;
      4'd7:    dec = 8'hF8;
      4'd8:    dec = 8'h80;
      4'd9:    dec = 8'h90;
      default: dec = 8'hBF;
    endcase
  endfunction

  always_comb begin
    slot_tick   = scan_cnt_q == SW'(SCAN_DIV - 1);
    scan_cnt_d  = slot_tick ? '0 : scan_cnt_q + 1'b1;
    idx_d       = !slot_tick ? idx_q : (idx_q >= 2'd2 ? 2'd0 : idx_q + 2'd1);
    blink_wrap  = blink_cnt_q == BW'(BLINK_DIV - 1);
    blink_cnt_d = (!game_over || blink_wrap) ? '0 : blink_cnt_q + 1'b1;
    blink_on_d  = !game_over ? 1'b1 : (blink_wrap ? !blink_on_q : blink_on_q);
    // Inputs are captured only at frame boundaries so a frame never mixes old and new digits
    snap        = load_q || (slot_tick && idx_q == 2'd2);
    d1_d        = snap ? time_1s : d1_q;
    d10_d       = snap ? time_10s : d10_q;
    d100_d      = snap ? time_100s : d100_q;
    max_d       = snap ? time_max_flag : max_q;
    blank_h     = !max_q && d100_q == 4'd0;
    blank_t     = blank_h && d10_q == 4'd0;
    digit       = idx_q == 2'd0 ? d1_q : idx_q == 2'd1 ? d10_q : d100_q;
    digit_blank = idx_q == 2'd1 ? blank_t : idx_q == 2'd2 ? blank_h : 1'b0;
    seg_on      = max_q ? (idx_q == 2'd2 ? 8'h10 : 8'h90) : digit_blank ? 8'hFF : dec(digit);
    off         = scan_cnt_q < SW'(BLANK_CYC) || !blink_on_q;
    sel_d       = off ? 3'b111 : ~(3'b001 << idx_q);
    seg_d       = off ? 8'hFF : seg_on;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      d1_q        <= 4'd0;
      d10_q       <= 4'd0;
      d100_q      <= 4'd0;
      max_q       <= 1'b0;
      load_q      <= 1'b1;
      sel_q       <= 3'b111;
      seg_q       <= 8'hFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      d1_q        <= d1_d;
      d10_q       <= d10_d;
      d100_q      <= d100_d;
      max_q       <= max_d;
      load_q      <= 1'b0;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_seg_time_display.sv
// tb_seg_time_display: directed bench for seg_time_display; expected {sel,seg} per cycle index
// since reset release are queued with the stimulus and checked when that cycle arrives.
module tb_seg_time_display;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] t1 = 4'd7, t10 = 4'd0, t100 = 4'd0;
  logic       mx = 1'b0, go = 1'b0;
  logic [2:0] sel;
  logic [7:0] seg;
  int         cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {int n; logic [10:0] exp; string tag;} chk_t;
  chk_t sb[$];

  seg_time_display #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(40)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .time_1s(t1), .time_10s(t10), .time_100s(t100),
    .time_max_flag(mx), .game_over(go), .sel(sel), .seg(seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;

  task automatic cmp(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed sel/seg=%h required %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input logic [2:0] s, input logic [7:0] g, input string tag);
    sb.push_back('{n, {s, g}, tag});
  endtask

  task automatic step();
    chk_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].n == cyc) begin
      e = sb.pop_front();
      cmp(e.tag, {sel, seg}, e.exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    chk_t e;
    repeat (3) @(negedge clk);
    cmp("reset", {sel, seg}, {3'b111, 8'hFF});
    rst_n = 1'b1;
    push(1,  3'b111, 8'hFF, "blank_s0");
    push(2,  3'b111, 8'hFF, "blank_s1");
    push(3,  3'b110, 8'hF8, "ones7");
    push(11, 3'b101, 8'hFF, "tens_lz");
    push(19, 3'b011, 8'hFF, "hund_lz");
    push(24, 3'b011, 8'hFF, "hund_end");
    goto(14); t1 = 4'd0; t100 = 4'd3;
    push(26, 3'b111, 8'hFF, "blank_win");
    push(27, 3'b110, 8'hC0, "ones0");
    push(35, 3'b101, 8'hC0, "tens0_shown");
    push(42, 3'b111, 8'hFF, "blank_hund");
    push(43, 3'b011, 8'hB0, "hund3");
    goto(38); t1 = 4'd2; t100 = 4'd0;
    push(51, 3'b110, 8'hA4, "ones2");
    push(67, 3'b011, 8'hFF, "midframe_hold");
    goto(58); t1 = 4'd5; t100 = 4'd1;
    push(75, 3'b110, 8'h92, "ones5_next");
    push(83, 3'b101, 8'hC0, "tens0_h1");
    push(91, 3'b011, 8'hF9, "hund1");
    goto(80); t1 = 4'd0; t100 = 4'd0; mx = 1'b1;
    push(99,  3'b110, 8'h90, "max_ones");
    push(107, 3'b101, 8'h90, "max_tens");
    push(115, 3'b011, 8'h10, "max_hund_dp");
    goto(100); mx = 1'b0; t1 = 4'd10;
    push(123, 3'b110, 8'hBF, "dash_ones");
    push(131, 3'b101, 8'hFF, "dash_tens_lz");
    push(139, 3'b011, 8'hFF, "dash_hund_lz");
    goto(125); t1 = 4'd0; t10 = 4'd12;
    push(147, 3'b110, 8'hC0, "ones0_b");
    push(155, 3'b101, 8'hBF, "dash_tens");
    push(163, 3'b011, 8'hFF, "hund_lz_b");
    goto(150); t1 = 4'd4; t10 = 4'd0;
    goto(170); go = 1'b1;
    push(171, 3'b110, 8'h99, "blink_on0");
    push(187, 3'b011, 8'hFF, "blink_on_h");
    push(195, 3'b110, 8'h99, "blink_on1");
    push(211, 3'b111, 8'hFF, "blink_off_first");
    push(219, 3'b111, 8'hFF, "blink_off_ones");
    push(243, 3'b111, 8'hFF, "blink_off_last");
    push(251, 3'b101, 8'hFF, "blink_on_again");
    push(267, 3'b110, 8'h99, "blink_on_ones");
    push(291, 3'b111, 8'hFF, "blink_off2");
    goto(291); go = 1'b0;
    push(292, 3'b111, 8'hFF, "go_drop_lag");
    push(293, 3'b110, 8'h99, "go_drop_on");
    push(315, 3'b110, 8'h99, "pre_reset");
    goto(315);
    rst_n = 1'b0; t1 = 4'd6;
    #1 cmp("reset_async", {sel, seg}, {3'b111, 8'hFF});
    @(negedge clk);
    cmp("reset_hold", {sel, seg}, {3'b111, 8'hFF});
    rst_n = 1'b1;
    push(1,  3'b111, 8'hFF, "rst_blank");
    push(3,  3'b110, 8'h82, "rst_reload");
    push(9,  3'b111, 8'hFF, "rst_blank_t");
    push(11, 3'b101, 8'hFF, "rst_tens_lz");
    push(19, 3'b011, 8'hFF, "rst_hund_lz");
    goto(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed no sample required %h", e.tag, e.exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
